// File: rtl/demux_1x16_seq.sv
// demux_1x16_seq: 1-to-16 serial demultiplexer with direct-select and auto-index deserializer modes
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   data_in    serial bit to route
//   in_valid   data_in is consumed on this edge
//   sel        target channel in direct mode
//   auto_mode  0 = direct demux, 1 = auto-index deserializer
//   out        registered channel bank (bit k = channel k)
//   out_valid  one-cycle pulse when the bank holds a fresh result
//   idx        current auto-mode write index
//   busy       auto-mode frame partially filled
//   frame_err  (only with DEMUX_FRAME_ERR_EN) one-cycle pulse after a frame abort
module demux_1x16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             in_valid,
  input  logic [3:0]       sel,
  input  logic             auto_mode,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [3:0]       idx,
  output logic             busy
`ifdef DEMUX_FRAME_ERR_EN
  ,
  output logic             frame_err
`endif
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             abort;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  // idx_q is held at 0 whenever the FSM is in IDLE, so it is the write
  // index in both states; an abort and a direct write may share one edge.
  always_comb begin
    abort       = (state_q == FILL) && !auto_mode;
    state_d     = abort ? IDLE : state_q;
    idx_d       = abort ? 4'd0 : idx_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (in_valid && auto_mode) begin
      out_d[idx_q] = data_in;
      state_d      = (idx_q == 4'd15) ? IDLE : FILL;
      idx_d        = idx_q + 4'd1;
      out_valid_d  = (idx_q == 4'd15);
    end else if (in_valid) begin
      out_d[sel]  = data_in;
      out_valid_d = 1'b1;
    end
  end
  always_comb begin
    out       = out_q;
    out_valid = out_valid_q;
    idx       = idx_q;
    busy      = (state_q == FILL);
  end
`ifdef DEMUX_FRAME_ERR_EN
  logic frame_err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= abort;
  assign frame_err = frame_err_q;
`endif
endmodule

// File: tb/tb_demux_1x16_seq.sv
// tb_demux_1x16_seq: directed self-checking bench for demux_1x16_seq
module tb_demux_1x16_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_in = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic        auto_mode = 1'b0;
  logic [15:0] out;
  logic        out_valid;
  logic [3:0]  idx;
  logic        busy;
`ifdef DEMUX_FRAME_ERR_EN
  logic        frame_err;
`endif
  int vectors = 0;
  int miscompares = 0;

  demux_1x16_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .sel(sel), .auto_mode(auto_mode), .out(out), .out_valid(out_valid),
    .idx(idx), .busy(busy)
`ifdef DEMUX_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; auto_mode = 1'b0; data_in = 1'b0; sel = 4'd0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({out, out_valid, idx, busy} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_state out=%h ov=%b idx=%0d busy=%b expected 0000/0/0/0", out, out_valid, idx, busy);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_direct();
    do_reset();
    sel = 4'd9; data_in = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out !== 16'h0200 || out_valid !== 1'b1 || idx !== 4'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_sel9 out=%h ov=%b idx=%0d busy=%b expected 0200/1/0/0", out, out_valid, idx, busy);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || out !== 16'h0200) begin
      miscompares++;
      $display("FAIL direct_pulse_end out=%h ov=%b expected 0200/0", out, out_valid);
    end
    sel = 4'd15; data_in = 1'b1; in_valid = 1'b1;
    step();
    sel = 4'd0;
    step();
    sel = 4'd9; data_in = 1'b0;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out !== 16'h8001 || idx !== 4'd0) begin
      miscompares++;
      $display("FAIL direct_bounds out=%h idx=%0d expected 8001/0", out, idx);
    end
  endtask

  task automatic test_frame();
    logic [15:0] pat = 16'hA5C3;
    int pulses = 0;
    int mid_pulses = 0;
    do_reset();
    auto_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = pat[i]; in_valid = 1'b1;
      step();
      if (out_valid) begin
        pulses++;
        if (i < 15) mid_pulses++;
      end
      if (i == 0) begin
        vectors++;
        if (idx !== 4'd1 || busy !== 1'b1 || out !== 16'h0001) begin
          miscompares++;
          $display("FAIL frame_first_bit idx=%0d busy=%b out=%h expected 1/1/0001", idx, busy, out);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (out !== 16'hA5C3 || busy !== 1'b0 || idx !== 4'd0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_done out=%h busy=%b idx=%0d ov=%b expected a5c3/0/0/1", out, busy, idx, out_valid);
    end
    vectors++;
    if (mid_pulses !== 0 || pulses !== 1) begin
      miscompares++;
      $display("FAIL frame_pulses mid=%0d total=%0d expected 0/1", mid_pulses, pulses);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_pulse_end ov=%b expected 0", out_valid);
    end
  endtask

  task automatic test_gap();
    logic [15:0] pat = 16'h3C96;
    int pulses = 0;
    do_reset();
    auto_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = pat[i]; in_valid = 1'b1;
      step();
      if (out_valid) pulses++;
    end
    in_valid = 1'b0; data_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) pulses++;
    end
    vectors++;
    if (idx !== 4'd8 || busy !== 1'b1 || out !== 16'h0096) begin
      miscompares++;
      $display("FAIL gap_hold idx=%0d busy=%b out=%h expected 8/1/0096", idx, busy, out);
    end
    for (int i = 8; i < 16; i++) begin
      data_in = pat[i]; in_valid = 1'b1;
      step();
      if (out_valid) pulses++;
    end
    in_valid = 1'b0;
    step();
    if (out_valid) pulses++;
    vectors++;
    if (out !== 16'h3C96 || pulses !== 1 || idx !== 4'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_frame out=%h pulses=%0d idx=%0d busy=%b expected 3c96/1/0/0", out, pulses, idx, busy);
    end
  endtask

  task automatic test_abort();
    logic [4:0] pat = 5'b10111;
    do_reset();
    auto_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = pat[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; auto_mode = 1'b0;
    step();
    vectors++;
    if (idx !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0 || out !== 16'h0017) begin
      miscompares++;
      $display("FAIL abort idx=%0d busy=%b ov=%b out=%h expected 0/0/0/0017", idx, busy, out_valid, out);
    end
`ifdef DEMUX_FRAME_ERR_EN
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_err_pulse got %b expected 1", frame_err);
    end
    step();
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_err_end got %b expected 0", frame_err);
    end
`endif
    auto_mode = 1'b1; data_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      step();
    end
    auto_mode = 1'b0; sel = 4'd12; data_in = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if (idx !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b1 || out !== 16'h1010) begin
      miscompares++;
      $display("FAIL abort_direct idx=%0d busy=%b ov=%b out=%h expected 0/0/1/1010", idx, busy, out_valid, out);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] pat = 16'h8421;
    int pulses = 0;
    do_reset();
    auto_mode = 1'b1; data_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out !== 16'h0000 || idx !== 4'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset out=%h idx=%0d busy=%b expected 0000/0/0", out, idx, busy);
    end
    step();
    rst_n = 1'b1;
    step();
    data_in = pat[0]; in_valid = 1'b1;
    step();
    vectors++;
    if (idx !== 4'd1 || out !== 16'h0001) begin
      miscompares++;
      $display("FAIL post_reset_first idx=%0d out=%h expected 1/0001", idx, out);
    end
    for (int i = 1; i < 16; i++) begin
      data_in = pat[i];
      step();
      if (out_valid) pulses++;
    end
    in_valid = 1'b0;
    vectors++;
    if (out !== 16'h8421 || pulses !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_frame out=%h pulses=%0d busy=%b expected 8421/1/0", out, pulses, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat = {16'h1357, 16'hF00D};
    int pulses = 0;
    int first = -1;
    int second = -1;
    do_reset();
    auto_mode = 1'b1;
    for (int c = 0; c < 32; c++) begin
      data_in = pat[c]; in_valid = 1'b1;
      step();
      if (out_valid) begin
        pulses++;
        if (first < 0) first = c; else second = c;
      end
      if (c == 15) begin
        vectors++;
        if (out !== 16'hF00D || idx !== 4'd0) begin
          miscompares++;
          $display("FAIL b2b_first out=%h idx=%0d expected f00d/0", out, idx);
        end
      end
      if (c == 16) begin
        vectors++;
        if (idx !== 4'd1 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_wrap idx=%0d busy=%b expected 1/1", idx, busy);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (pulses !== 2 || first !== 15 || second !== 31 || out !== 16'h1357) begin
      miscompares++;
      $display("FAIL b2b_pulses n=%0d at %0d,%0d out=%h expected 2 at 15,31 out=1357", pulses, first, second, out);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_frame();
    test_gap();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
